// File: rtl/dma_page_ctl.sv
// DMA page register controller: decodes CPU page-port writes into a setup/strobe/hold
// sequence on a 74LS670-style register file and reads the page for the active DACK.
// Optional CPU readback is built only when DMA_PAGE_READBACK_EN is defined.
module dma_page_ctl #(
  parameter int STROBE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_wr,
  input  logic       io_rd,
  input  logic [3:0] io_addr,
  input  logic [3:0] io_data,
  input  logic [3:0] dack,
  output logic [3:0] page_out,
  output logic       page_valid,
  output logic [3:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       wr_overrun,
  output logic [3:0] rf_d,
  output logic       rf_wa,
  output logic       rf_wb,
  output logic       rf_write,
  output logic       rf_ra,
  output logic       rf_rb,
  output logic       rf_read,
  input  logic [3:0] rf_q
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} wr_state_t;

  localparam logic [1:0] STROBE_LAST = 2'(STROBE_CYCLES - 1);

  // Returns {hit, channel}; the page ports are scattered across the low nibble.
  function automatic logic [2:0] map_port(input logic [3:0] addr);
    case (addr)
      4'd7:    map_port = 3'b100;
      4'd3:    map_port = 3'b101;
      4'd1:    map_port = 3'b110;
      4'd2:    map_port = 3'b111;
      default: map_port = 3'b000;
    endcase
  endfunction

  wr_state_t  state, state_nxt;
  logic [1:0] cur_ch, pend_ch, strobe_cnt;
  logic [3:0] cur_data, pend_data;
  logic       pend_valid;
  logic       load_new, load_pend, store_pend, clear_pend, drop;
  logic [2:0] wr_map;
  logic       wr_hit;

  assign wr_map = map_port(io_addr);
  assign wr_hit = io_wr & wr_map[2];

  always_comb begin
    state_nxt  = state;
    load_new   = 1'b0;
    load_pend  = 1'b0;
    store_pend = 1'b0;
    clear_pend = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (wr_hit) begin
          state_nxt = SETUP;
          load_new  = 1'b1;
        end
      end
      SETUP, STROBE: begin
        if (state == SETUP || strobe_cnt == STROBE_LAST) begin
          state_nxt = (state == SETUP) ? STROBE : HOLD;
        end
        if (wr_hit) begin
          store_pend = ~pend_valid;
          drop       = pend_valid;
        end
      end
      HOLD: begin
        // Popping the slot frees it in the same edge, so a new write refills it.
        if (pend_valid) begin
          state_nxt  = SETUP;
          load_pend  = 1'b1;
          store_pend = wr_hit;
          clear_pend = ~wr_hit;
        end else if (wr_hit) begin
          state_nxt = SETUP;
          load_new  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_ch     <= 2'd0;
      cur_data   <= 4'd0;
      pend_valid <= 1'b0;
      pend_ch    <= 2'd0;
      pend_data  <= 4'd0;
      strobe_cnt <= 2'd0;
      wr_overrun <= 1'b0;
    end else begin
      state      <= state_nxt;
      strobe_cnt <= (state == STROBE) ? strobe_cnt + 2'd1 : 2'd0;
      if (load_new) begin
        cur_ch   <= wr_map[1:0];
        cur_data <= io_data;
      end else if (load_pend) begin
        cur_ch   <= pend_ch;
        cur_data <= pend_data;
      end
      if (store_pend) begin
        pend_valid <= 1'b1;
        pend_ch    <= wr_map[1:0];
        pend_data  <= io_data;
      end else if (clear_pend) begin
        pend_valid <= 1'b0;
      end
      if (drop) begin
        wr_overrun <= 1'b1;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign rf_write = (state == STROBE);
  assign rf_d     = cur_data;
  assign rf_wa    = cur_ch[0];
  assign rf_wb    = cur_ch[1];

  // Lowest-numbered acknowledged channel owns the read port.
  logic [1:0] dack_sel;
  logic       dack_any;
  logic [1:0] rd_ch;

  assign dack_any = |dack;

  always_comb begin
    dack_sel = 2'd0;
    if (dack[0])      dack_sel = 2'd0;
    else if (dack[1]) dack_sel = 2'd1;
    else if (dack[2]) dack_sel = 2'd2;
    else if (dack[3]) dack_sel = 2'd3;
  end

  assign rf_ra = rd_ch[0];
  assign rf_rb = rd_ch[1];

`ifdef DMA_PAGE_READBACK_EN
  logic [2:0] rd_map;
  logic       cpu_pend, cpu_inflight, cpu_zero, rd_is_dma;
  logic [1:0] cpu_ch;

  assign rd_map = map_port(io_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ch        <= 2'd0;
      rf_read      <= 1'b0;
      rd_is_dma    <= 1'b0;
      page_out     <= 4'd0;
      page_valid   <= 1'b0;
      cpu_pend     <= 1'b0;
      cpu_inflight <= 1'b0;
      cpu_zero     <= 1'b0;
      cpu_ch       <= 2'd0;
      rd_data      <= 4'd0;
      rd_valid     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (dack_any) begin
        rf_read   <= 1'b1;
        rd_ch     <= dack_sel;
        rd_is_dma <= 1'b1;
      end else if (cpu_pend) begin
        rf_read      <= 1'b1;
        rd_ch        <= cpu_ch;
        rd_is_dma    <= 1'b0;
        cpu_pend     <= 1'b0;
        cpu_inflight <= 1'b1;
      end else begin
        rf_read <= 1'b0;
      end
      if (io_rd && !cpu_pend && !cpu_inflight) begin
        cpu_pend <= 1'b1;
        cpu_ch   <= rd_map[1:0];
        cpu_zero <= ~rd_map[2];
      end
      if (cpu_inflight) begin
        cpu_inflight <= 1'b0;
        rd_valid     <= 1'b1;
        rd_data      <= cpu_zero ? 4'd0 : rf_q;
      end
      if (rf_read && rd_is_dma && dack_any && dack_sel == rd_ch) begin
        page_valid <= 1'b1;
        page_out   <= rf_q;
      end else begin
        page_valid <= 1'b0;
      end
    end
  end
`else
  logic unused_io_rd;
  assign unused_io_rd = io_rd;
  assign rd_data      = 4'd0;
  assign rd_valid     = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ch      <= 2'd0;
      rf_read    <= 1'b0;
      page_out   <= 4'd0;
      page_valid <= 1'b0;
    end else begin
      rf_read <= dack_any;
      if (dack_any) begin
        rd_ch <= dack_sel;
      end
      if (rf_read && dack_any && dack_sel == rd_ch) begin
        page_valid <= 1'b1;
        page_out   <= rf_q;
      end else begin
        page_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dma_page_ctl.sv
// Bench for dma_page_ctl: directed scenarios plus random traffic checked each cycle
// against a transaction-level model of the write queue, page shadow and read pipeline.
module tb_dma_page_ctl;

  localparam int S = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       io_wr = 1'b0;
  logic       io_rd = 1'b0;
  logic [3:0] io_addr = 4'd0;
  logic [3:0] io_data = 4'd0;
  logic [3:0] dack = 4'd0;
  logic [3:0] page_out, rd_data, rf_d, rf_q;
  logic       page_valid, rd_valid, busy, wr_overrun;
  logic       rf_wa, rf_wb, rf_write, rf_ra, rf_rb, rf_read;

  logic [3:0] rf_mem [4];

  int checkCount = 0;
  int passCount  = 0;

  dma_page_ctl #(.STROBE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .io_wr(io_wr), .io_rd(io_rd), .io_addr(io_addr),
    .io_data(io_data), .dack(dack), .page_out(page_out), .page_valid(page_valid),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .wr_overrun(wr_overrun),
    .rf_d(rf_d), .rf_wa(rf_wa), .rf_wb(rf_wb), .rf_write(rf_write),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_read(rf_read), .rf_q(rf_q)
  );

  always #5 clk = ~clk;

  // Register file part: written while rf_write is high, read port gated by rf_read.
  always @(posedge clk) begin
    if (rf_write) rf_mem[{rf_wb, rf_wa}] <= rf_d;
  end
  assign rf_q = rf_read ? rf_mem[{rf_rb, rf_ra}] : 4'h0;

  // Model: an active write job with a phase counter (0 setup, 1..S strobe, S+1 hold).
  bit         mActive = 0;
  int         mPhase = 0;
  logic [1:0] mCh = 2'd0;
  logic [3:0] mData = 4'd0;
  logic [5:0] mPend [$];
  bit         mOverrun = 0;
  logic [3:0] mMem [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] mDackPrev = 4'd0;
  bit         mPageValid = 0;
  logic [3:0] mPageOut = 4'd0;

  function automatic int portCh(input logic [3:0] a);
    case (a)
      4'd7:    return 0;
      4'd3:    return 1;
      4'd1:    return 2;
      4'd2:    return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int lowCh(input logic [3:0] d);
    for (int i = 0; i < 4; i++) if (d[i]) return i;
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic modelStep(input logic r, input logic w, input logic [3:0] a,
                           input logic [3:0] d, input logic [3:0] k);
    int nc;
    int cs;
    int ps;
    bit nw;
    nc = portCh(a);
    cs = lowCh(k);
    ps = lowCh(mDackPrev);
    nw = w && (nc >= 0);
    if (ps >= 0 && cs == ps) begin
      mPageValid = 1;
      mPageOut   = mMem[ps];
    end else begin
      mPageValid = 0;
    end
    if (mActive && mPhase >= 1 && mPhase <= S) mMem[mCh] = mData;
    if (r) begin
      mActive = 0; mPhase = 0; mPend.delete(); mOverrun = 0;
      mDackPrev = 4'd0; mPageValid = 0; mPageOut = 4'd0;
      return;
    end
    if (!mActive) begin
      if (nw) begin mActive = 1; mPhase = 0; mCh = 2'(nc); mData = d; end
    end else if (mPhase == S + 1) begin
      if (mPend.size() > 0) begin
        {mCh, mData} = mPend.pop_front();
        mPhase = 0;
        if (nw) mPend.push_back({2'(nc), d});
      end else if (nw) begin
        mPhase = 0; mCh = 2'(nc); mData = d;
      end else begin
        mActive = 0;
      end
    end else begin
      mPhase++;
      if (nw) begin
        if (mPend.size() == 0) mPend.push_back({2'(nc), d});
        else mOverrun = 1;
      end
    end
    mDackPrev = k;
  endtask

  task automatic compareAll();
    checkOutput("busy", 8'(busy), 8'(mActive));
    checkOutput("rf_write", 8'(rf_write), 8'(mActive && mPhase >= 1 && mPhase <= S));
    checkOutput("wr_overrun", 8'(wr_overrun), 8'(mOverrun));
    if (mActive) begin
      checkOutput("rf_waddr", 8'({rf_wb, rf_wa}), 8'(mCh));
      checkOutput("rf_d", 8'(rf_d), 8'(mData));
    end
    checkOutput("rf_read", 8'(rf_read), 8'(mDackPrev != 4'd0));
    if (mDackPrev != 4'd0) checkOutput("rf_raddr", 8'({rf_rb, rf_ra}), 8'(lowCh(mDackPrev)));
    checkOutput("page_valid", 8'(page_valid), 8'(mPageValid));
    checkOutput("page_out", 8'(page_out), 8'(mPageOut));
`ifndef DMA_PAGE_READBACK_EN
    checkOutput("rd_valid_tied", 8'(rd_valid), 8'd0);
    checkOutput("rd_data_tied", 8'(rd_data), 8'd0);
`endif
  endtask

  // One clock: check the current cycle, then drive this cycle's inputs.
  task automatic applyStimulus(input logic r, input logic w, input logic [3:0] a,
                               input logic [3:0] d, input logic [3:0] k);
    @(posedge clk); #1;
    compareAll();
    reset = r; io_wr = w; io_addr = a; io_data = d; dack = k;
    modelStep(r, w, a, d, k);
  endtask

  task automatic idle(input int n, input logic [3:0] k);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, k);
  endtask

  initial begin
    logic [3:0] curDack;
    logic [3:0] ports [4];
    ports = '{4'd7, 4'd3, 4'd1, 4'd2};

    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
    applyStimulus(1'b0, 1'b1, 4'd3, 4'hA, 4'd0);
    idle(S + 4, 4'd0);
    checkOutput("single_write_done", 8'(busy), 8'd0);

    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b1, ports[c], 4'(c + 1), 4'd0);
      idle(S + 3, 4'd0);
    end
    idle(3, 4'b0100);
    checkOutput("dack_ch2_page", 8'(page_out), 8'd3);
    idle(3, 4'b1010);
    checkOutput("dack_ch1_wins", 8'(page_out), 8'd2);

    applyStimulus(1'b0, 1'b1, 4'd7, 4'h5, 4'd0);
    applyStimulus(1'b0, 1'b1, 4'd3, 4'h6, 4'd0);
    applyStimulus(1'b0, 1'b1, 4'd1, 4'h7, 4'd0);
    idle(2 * S + 6, 4'd0);
    checkOutput("triple_overrun", 8'(wr_overrun), 8'd1);
    checkOutput("triple_drop_ch2", 8'(mMem[2]), 8'd3);
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);

    applyStimulus(1'b0, 1'b1, 4'd5, 4'hF, 4'd0);
    idle(S + 3, 4'd0);

    applyStimulus(1'b0, 1'b1, 4'd7, 4'h9, 4'd0);
    applyStimulus(1'b0, 1'b1, 4'd3, 4'h8, 4'd0);
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
    idle(S + 4, 4'b0010);
    checkOutput("reset_discards_pend", 8'(page_out), 8'd6);

    curDack = 4'd0;
    for (int n = 0; n < 2500; n++) begin
      logic       r;
      logic       w;
      logic [3:0] a;
      r = ($urandom_range(0, 299) == 0);
      w = ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : ports[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) == 0)
        curDack = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      applyStimulus(r, w, a, 4'($urandom_range(0, 15)), curDack);
    end
    applyStimulus(1'b0, 1'b1, 4'd2, 4'hC, 4'd0);
    idle(S + 4, 4'd0);

`ifdef DMA_PAGE_READBACK_EN
    @(posedge clk); #1;
    dack = 4'b0001; io_rd = 1'b1; io_addr = 4'd2;
    @(posedge clk); #1;
    io_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("rb_deferred", 8'(rd_valid), 8'd0);
    end
    dack = 4'd0;
    @(posedge clk); #1;
    checkOutput("rb_not_early", 8'(rd_valid), 8'd0);
    checkOutput("rb_no_page_valid", 8'(page_valid), 8'd0);
    @(posedge clk); #1;
    checkOutput("rb_valid", 8'(rd_valid), 8'd1);
    checkOutput("rb_data_ch3", 8'(rd_data), 8'(mMem[3]));
    @(posedge clk); #1;
    checkOutput("rb_one_pulse", 8'(rd_valid), 8'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
